// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port SRAM (unified I/D memory) between an
//            instruction-fetch requester (I) and a load/store requester (D).
//            Grants one requester per cycle, drives the SRAM pins and
//            returns the one-cycle-latency read data to the issuer of the
//            read. Fetch is protected against starvation, and stalled fetch
//            cycles are counted.
// Ports    : CLK, RST        - clock, synchronous active-high reset
//            I_REQ/I_ADDR    - fetch request and word address
//            I_GNT           - fetch accepted this cycle
//            I_RVALID/I_RDATA- fetch read return
//            D_REQ/D_WEN/D_BE/D_ADDR/D_WDATA - data request (D_WEN=1 read)
//            D_GNT           - data request accepted this cycle
//            D_RVALID/D_RDATA- load read return
//            M_CSN/M_WEN/M_BE/M_ADDR/M_DI - SRAM control/address/write data
//            M_DOUT          - SRAM read data, one cycle after a read
//            I_STALL_CNT     - cycles with I_REQ=1 and I_GNT=0
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AWIDTH     = 12,
  parameter int DWIDTH     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [AWIDTH-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [DWIDTH-1:0] I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WEN,
  input  logic [3:0]        D_BE,
  input  logic [AWIDTH-1:0] D_ADDR,
  input  logic [DWIDTH-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DWIDTH-1:0] D_RDATA,
  output logic              M_CSN,
  output logic              M_WEN,
  output logic [3:0]        M_BE,
  output logic [AWIDTH-1:0] M_ADDR,
  output logic [DWIDTH-1:0] M_DI,
  input  logic [DWIDTH-1:0] M_DOUT,
  output logic [31:0]       I_STALL_CNT
);

  localparam logic [3:0] C_STARVE_LIM = 4'(STARVE_LIM);

  // Owner of the read issued in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t      r_owner;
  owner_t      w_owner_nxt;
  logic [3:0]  r_wait;
  logic [3:0]  w_wait_nxt;
  logic [31:0] r_stall_cnt;
  logic        w_i_win;
  logic        w_d_win;
  logic        w_i_stalled;

  // Arbitration, SRAM pin drive and next-state logic.
  always_comb begin
    w_i_win     = 1'b0;
    w_d_win     = 1'b0;
    M_CSN       = 1'b1;
    M_WEN       = 1'b1;
    M_BE        = 4'b0000;
    M_ADDR      = '0;
    M_DI        = '0;
    w_owner_nxt = OWN_NONE;
    w_wait_nxt  = 4'd0;

    if (!RST) begin
      if (I_REQ && D_REQ) begin
        // D normally wins contention; I wins once it has waited long enough.
        if (r_wait >= C_STARVE_LIM) begin
          w_i_win = 1'b1;
        end else begin
          w_d_win = 1'b1;
        end
      end else begin
        w_i_win = I_REQ;
        w_d_win = D_REQ;
      end
    end

    if (w_i_win) begin
      M_CSN       = 1'b0;
      M_ADDR      = I_ADDR;
      w_owner_nxt = OWN_I;
    end else if (w_d_win) begin
      M_CSN       = 1'b0;
      M_WEN       = D_WEN;
      M_BE        = D_BE;
      M_ADDR      = D_ADDR;
      M_DI        = D_WDATA;
      w_owner_nxt = D_WEN ? OWN_D : OWN_NONE;
    end

    w_i_stalled = I_REQ && !w_i_win;
    if (w_i_stalled) begin
      w_wait_nxt = (r_wait == 4'hF) ? r_wait : r_wait + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_owner     <= OWN_NONE;
      r_wait      <= 4'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_owner <= w_owner_nxt;
      r_wait  <= w_wait_nxt;
      if (w_i_stalled) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign I_GNT       = w_i_win;
  assign D_GNT       = w_d_win;
  assign I_STALL_CNT = r_stall_cnt;

  // Return is masked while RST is high so a read issued just before reset
  // never surfaces.
  assign I_RVALID = (r_owner == OWN_I) && !RST;
  assign D_RVALID = (r_owner == OWN_D) && !RST;
  assign I_RDATA  = I_RVALID ? M_DOUT : '0;
  assign D_RDATA  = D_RVALID ? M_DOUT : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter: directed scenarios
//            followed by constrained-random requests, all compared against
//            a behavioural arbiter + memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          I_REQ;
  logic [AW-1:0] I_ADDR;
  logic          I_GNT;
  logic          I_RVALID;
  logic [DW-1:0] I_RDATA;
  logic          D_REQ;
  logic          D_WEN;
  logic [3:0]    D_BE;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          D_GNT;
  logic          D_RVALID;
  logic [DW-1:0] D_RDATA;
  logic          M_CSN;
  logic          M_WEN;
  logic [3:0]    M_BE;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_DI;
  logic [DW-1:0] M_DOUT;
  logic [31:0]   I_STALL_CNT;

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_LIM(LIM)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT),
    .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WEN(D_WEN), .D_BE(D_BE), .D_ADDR(D_ADDR),
    .D_WDATA(D_WDATA), .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_CSN(M_CSN), .M_WEN(M_WEN), .M_BE(M_BE), .M_ADDR(M_ADDR),
    .M_DI(M_DI), .M_DOUT(M_DOUT), .I_STALL_CNT(I_STALL_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_word(input int a);
    case (a)
      'h004:   return 32'h00500093;
      'h010:   return 32'h00000011;
      'h020:   return 32'h00000022;
      default: return 32'(a) * 32'h9E3779B1;
    endcase
  endfunction

  // SRAM behavioural model driven by the DUT pins.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_init = 1'b0;
  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int a = 0; a < (1<<AW); a++) mem[a] <= init_word(a);
      mem_init <= 1'b1;
    end else if (!M_CSN) begin
      if (M_WEN) begin
        M_DOUT <= mem[M_ADDR];
      end else begin
        for (int b = 0; b < 4; b++)
          if (M_BE[b]) mem[M_ADDR][8*b +: 8] <= M_DI[8*b +: 8];
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            waited;     // consecutive cycles I has been denied
  logic [31:0]   stall;
  int            pend;       // 0 none, 1 I, 2 D
  logic [DW-1:0] pend_data;
  logic          e_ig, e_dg;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_check();
    logic          e_iv, e_dv;
    logic [AW-1:0] e_addr;
    @(negedge CLK);
    e_ig = 1'b0;
    e_dg = 1'b0;
    if (!RST) begin
      if (I_REQ && D_REQ) begin
        e_ig = (waited >= LIM);
        e_dg = !e_ig;
      end else begin
        e_ig = I_REQ;
        e_dg = D_REQ;
      end
    end
    e_addr = e_ig ? I_ADDR : (e_dg ? D_ADDR : '0);
    e_iv = (pend == 1) && !RST;
    e_dv = (pend == 2) && !RST;
    chk("i_gnt",    64'(I_GNT),    64'(e_ig));
    chk("d_gnt",    64'(D_GNT),    64'(e_dg));
    chk("m_csn",    64'(M_CSN),    64'(!(e_ig || e_dg)));
    chk("m_wen",    64'(M_WEN),    64'(e_dg ? D_WEN : 1'b1));
    chk("m_be",     64'(M_BE),     64'(e_dg ? D_BE : 4'b0));
    chk("m_addr",   64'(M_ADDR),   64'(e_addr));
    chk("m_di",     64'(M_DI),     64'(e_dg ? D_WDATA : '0));
    chk("i_rvalid", 64'(I_RVALID), 64'(e_iv));
    chk("d_rvalid", 64'(D_RVALID), 64'(e_dv));
    chk("i_rdata",  64'(I_RDATA),  64'(e_iv ? pend_data : '0));
    chk("d_rdata",  64'(D_RDATA),  64'(e_dv ? pend_data : '0));
    chk("stall",    64'(I_STALL_CNT), 64'(stall));
  endtask

  task automatic step_adv();
    @(posedge CLK);
    if (RST) begin
      waited = 0;
      stall  = 0;
      pend   = 0;
    end else begin
      if (I_REQ && !e_ig) begin
        waited = (waited < 15) ? waited + 1 : 15;
        stall  = stall + 1;
      end else begin
        waited = 0;
      end
      pend      = e_ig ? 1 : ((e_dg && D_WEN) ? 2 : 0);
      pend_data = e_ig ? shadow[I_ADDR] : shadow[D_ADDR];
      if (e_dg && !D_WEN)
        for (int b = 0; b < 4; b++)
          if (D_BE[b]) shadow[D_ADDR][8*b +: 8] = D_WDATA[8*b +: 8];
    end
    #1;
  endtask

  task automatic step();
    step_check();
    step_adv();
  endtask

  task automatic set_i(input logic req, input logic [AW-1:0] a);
    I_REQ  = req;
    I_ADDR = a;
  endtask

  task automatic set_d(input logic req, input logic wen, input logic [3:0] be,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    D_REQ   = req;
    D_WEN   = wen;
    D_BE    = be;
    D_ADDR  = a;
    D_WDATA = wd;
  endtask

  initial begin
    for (int a = 0; a < (1<<AW); a++) shadow[a] = init_word(a);
    waited = 0; stall = 0; pend = 0; pend_data = '0;
    RST = 1'b1;
    set_i(1'b1, 12'h004);
    set_d(1'b1, 1'b1, 4'hF, 12'h010, 32'h0);
    @(posedge CLK);
    #1;

    // Reset held with both requesting.
    repeat (3) step();

    // Single fetch.
    RST = 1'b0;
    set_d(1'b0, 1'b1, 4'h0, 12'h000, 32'h0);
    set_i(1'b1, 12'h004);
    step();
    set_i(1'b0, 12'h000);
    step_check();
    chk("fetch_data", 64'(I_RDATA), 64'h00500093);
    step_adv();

    // Store then load.
    set_d(1'b1, 1'b0, 4'hF, 12'h100, 32'h000000AA);
    step();
    set_d(1'b1, 1'b1, 4'hF, 12'h100, 32'h0);
    step();
    set_d(1'b0, 1'b1, 4'h0, 12'h000, 32'h0);
    step_check();
    chk("load_data", 64'(D_RDATA), 64'h000000AA);
    step_adv();

    // Sustained contention.
    set_i(1'b1, 12'h020);
    set_d(1'b1, 1'b1, 4'hF, 12'h010, 32'h0);
    for (int k = 0; k < 6; k++) begin
      step_check();
      chk("cont_dgnt", 64'(D_GNT), (k == 4) ? 64'd0 : 64'd1);
      if (k == 5) chk("cont_stall", 64'(I_STALL_CNT), 64'd4);
      step_adv();
    end
    set_i(1'b0, 12'h000);
    set_d(1'b0, 1'b1, 4'h0, 12'h000, 32'h0);
    step();

    // Alternating owners back to back.
    set_d(1'b1, 1'b1, 4'hF, 12'h010, 32'h0);
    step();
    set_d(1'b0, 1'b1, 4'h0, 12'h000, 32'h0);
    set_i(1'b1, 12'h020);
    step_check();
    chk("alt_d_data", 64'(D_RDATA), 64'h11);
    step_adv();
    set_i(1'b0, 12'h000);
    step_check();
    chk("alt_i_data", 64'(I_RDATA), 64'h22);
    chk("alt_d_idle", 64'(D_RVALID), 64'd0);
    step_adv();

    // Reset arriving right after a granted fetch.
    set_i(1'b1, 12'h004);
    step();
    set_i(1'b0, 12'h000);
    RST = 1'b1;
    step_check();
    chk("rst_mid_rvalid", 64'(I_RVALID), 64'd0);
    step_adv();
    RST = 1'b0;
    step();
    set_i(1'b1, 12'h020);
    step();
    set_i(1'b0, 12'h000);
    step_check();
    chk("post_rst_fetch", 64'(I_RDATA), 64'h22);
    step_adv();

    // Randomised traffic; requests stay stable until the model grants them.
    for (int k = 0; k < 400; k++) begin
      if (!I_REQ || e_ig)
        set_i($urandom_range(0, 99) < 60, AW'($urandom_range(0, 63)));
      if (!D_REQ || e_dg)
        set_d($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
              4'($urandom), AW'($urandom_range(0, 63)), $urandom);
      RST = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
